// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared register-number types and forward-select encoding
//
// Contents:
//   RNW        register-number width
//   RZERO      hard-wired zero register number
//   fwd_e      operand source select (FWD_RF, FWD_EX, FWD_MEM, FWD_WB)
//   reg_hit()  true when a writing stage targets a nonzero source register

package operand_fetch_pkg;

    localparam int RNW = 5;
    localparam logic [RNW-1:0] RZERO = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_e;

    function automatic logic reg_hit(
        input logic           wreg,
        input logic [RNW-1:0] wn,
        input logic [RNW-1:0] src
    );
        return wreg && (wn == src) && (src != RZERO);
    endfunction

endpackage

// File: rtl/operand_fetch_fwd_sel.sv
// rtl/operand_fetch_fwd_sel.sv - per-source forwarding select and operand mux
//
// Ports:
//   src, use_src                  source register number and whether it is read
//   ex_wreg, ex_m2reg, ex_wn, ex_alu   EX stage destination info and ALU result
//   mem_wreg, mem_wn, mem_data    MEM stage destination info and result
//   wb_wreg, wb_wn, wb_data       WB stage destination info and write data
//   q                             regfile read data for src
//   operand                       resolved operand value
//   stall                         this source cannot be resolved this cycle
//
// Build option: OPFETCH_WB_BYPASS_EN enables forwarding of wb_data; without it
// a WB match on a used source stalls until the regfile write has landed.

module fwd_sel
    import operand_fetch_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [RNW-1:0] src,
    input  logic           use_src,
    input  logic           ex_wreg,
    input  logic           ex_m2reg,
    input  logic [RNW-1:0] ex_wn,
    input  logic [DW-1:0]  ex_alu,
    input  logic           mem_wreg,
    input  logic [RNW-1:0] mem_wn,
    input  logic [DW-1:0]  mem_data,
    input  logic           wb_wreg,
    input  logic [RNW-1:0] wb_wn,
    input  logic [DW-1:0]  wb_data,
    input  logic [DW-1:0]  q,
    output logic [DW-1:0]  operand,
    output logic           stall
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;
    fwd_e sel;

    assign ex_hit  = reg_hit(ex_wreg, ex_wn, src);
    assign mem_hit = reg_hit(mem_wreg, mem_wn, src);
    assign wb_hit  = reg_hit(wb_wreg, wb_wn, src);

    // A load in EX has no data yet, so it is skipped as a forwarding source
    // and instead raises a stall when the operand is actually consumed.
    always_comb begin
        sel   = FWD_RF;
        stall = 1'b0;
        if (ex_hit && !ex_m2reg) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
`ifdef OPFETCH_WB_BYPASS_EN
            sel = FWD_WB;
`else
            // Regfile write happens at this edge; read it back next cycle.
            sel   = FWD_RF;
            stall = use_src;
`endif
        end
        if (ex_hit && ex_m2reg) begin
            stall = use_src;
        end
    end

    always_comb begin
        operand = q;
        unique case (sel)
            FWD_EX:  operand = ex_alu;
            FWD_MEM: operand = mem_data;
            FWD_WB:  operand = wb_data;
            default: operand = q;
        endcase
        if (src == RZERO) begin
            operand = '0;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand resolution with forwarding, hazard stall and ID/EX register
//
// Ports:
//   clk, clrn                     clock (rising edge), async active-low reset
//   in_valid/in_ready, in_pc      decoded instruction handshake and PC
//   rs, rt, use_rs, use_rt        source registers and read enables
//   rna, rnb / qa, qb             regfile read addresses / read data
//   ex_*, mem_*, wb_*             downstream stage write-back info for forwarding
//   flush                         squash on branch/jump redirect
//   out_valid/out_ready           ID/EX handshake toward execute
//   out_pc, out_a, out_b          registered PC and resolved operands
//   hazard, stall_cnt             stall this cycle, saturating stall-cycle count
//
// Build option: OPFETCH_WB_BYPASS_EN (see fwd_sel).

module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_pc,
    input  logic [RNW-1:0]  rs,
    input  logic [RNW-1:0]  rt,
    input  logic            use_rs,
    input  logic            use_rt,
    output logic [RNW-1:0]  rna,
    output logic [RNW-1:0]  rnb,
    input  logic [DW-1:0]   qa,
    input  logic [DW-1:0]   qb,
    input  logic            ex_wreg,
    input  logic            ex_m2reg,
    input  logic [RNW-1:0]  ex_wn,
    input  logic [DW-1:0]   ex_alu,
    input  logic            mem_wreg,
    input  logic [RNW-1:0]  mem_wn,
    input  logic [DW-1:0]   mem_data,
    input  logic            wb_wreg,
    input  logic [RNW-1:0]  wb_wn,
    input  logic [DW-1:0]   wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_pc,
    output logic [DW-1:0]   out_a,
    output logic [DW-1:0]   out_b,
    output logic            hazard,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          stall_a;
    logic          stall_b;
    logic          upd;
    logic          accept;

    assign rna = rs;
    assign rnb = rt;

    fwd_sel #(.DW(DW)) u_fwd_a (
        .src      (rs),
        .use_src  (use_rs),
        .ex_wreg  (ex_wreg),
        .ex_m2reg (ex_m2reg),
        .ex_wn    (ex_wn),
        .ex_alu   (ex_alu),
        .mem_wreg (mem_wreg),
        .mem_wn   (mem_wn),
        .mem_data (mem_data),
        .wb_wreg  (wb_wreg),
        .wb_wn    (wb_wn),
        .wb_data  (wb_data),
        .q        (qa),
        .operand  (opa),
        .stall    (stall_a)
    );

    fwd_sel #(.DW(DW)) u_fwd_b (
        .src      (rt),
        .use_src  (use_rt),
        .ex_wreg  (ex_wreg),
        .ex_m2reg (ex_m2reg),
        .ex_wn    (ex_wn),
        .ex_alu   (ex_alu),
        .mem_wreg (mem_wreg),
        .mem_wn   (mem_wn),
        .mem_data (mem_data),
        .wb_wreg  (wb_wreg),
        .wb_wn    (wb_wn),
        .wb_data  (wb_data),
        .q        (qb),
        .operand  (opb),
        .stall    (stall_b)
    );

    assign hazard   = in_valid & (stall_a | stall_b);
    assign upd      = ~out_valid | out_ready;
    assign in_ready = upd & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    // ID/EX register. flush wins over both capture and the backpressure hold;
    // a bubble keeps the previous data so downstream sees no gratuitous toggles.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_a     <= '0;
            out_b     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (upd) begin
            out_valid <= accept;
            if (accept) begin
                out_pc <= in_pc;
                out_a  <= opa;
                out_b  <= opb;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch

module tb_operand_fetch;

    localparam int DW   = 32;
    localparam int CNTW = 16;
`ifdef OPFETCH_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            clrn;
    logic            in_valid, in_ready;
    logic [DW-1:0]   in_pc;
    logic [4:0]      rs, rt, rna, rnb;
    logic            use_rs, use_rt;
    logic [DW-1:0]   qa, qb;
    logic            ex_wreg, ex_m2reg;
    logic [4:0]      ex_wn;
    logic [DW-1:0]   ex_alu;
    logic            mem_wreg;
    logic [4:0]      mem_wn;
    logic [DW-1:0]   mem_data;
    logic            wb_wreg;
    logic [4:0]      wb_wn;
    logic [DW-1:0]   wb_data;
    logic            flush;
    logic            out_valid, out_ready;
    logic [DW-1:0]   out_pc, out_a, out_b;
    logic            hazard;
    logic [CNTW-1:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    operand_fetch #(.DW(DW), .CNTW(CNTW)) dut (
        .clk(clk), .clrn(clrn),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wn(ex_wn), .ex_alu(ex_alu),
        .mem_wreg(mem_wreg), .mem_wn(mem_wn), .mem_data(mem_data),
        .wb_wreg(wb_wreg), .wb_wn(wb_wn), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_a(out_a), .out_b(out_b),
        .hazard(hazard), .stall_cnt(stall_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle();
        in_valid = 0; in_pc = '0; rs = '0; rt = '0; use_rs = 0; use_rt = 0;
        qa = '0; qb = '0; ex_wreg = 0; ex_m2reg = 0; ex_wn = '0; ex_alu = '0;
        mem_wreg = 0; mem_wn = '0; mem_data = '0; wb_wreg = 0; wb_wn = '0;
        wb_data = '0; flush = 0; out_ready = 1;
    endtask

    // Reference resolution: walk the writers youngest-first and take the
    // first one that names the source; a load in EX has nothing to give yet,
    // and without the WB bypass a WB writer means "wait for the regfile".
    typedef struct packed { logic stall; logic [DW-1:0] val; } res_t;

    function automatic res_t resolve(input logic [4:0] src, input logic use_it, input logic [DW-1:0] q);
        res_t r;
        logic       w[3];
        logic [4:0] n[3];
        logic [DW-1:0] d[3];
        w = '{ex_wreg, mem_wreg, wb_wreg};
        n = '{ex_wn, mem_wn, wb_wn};
        d = '{ex_alu, mem_data, wb_data};
        r.stall = 1'b0;
        r.val   = q;
        if (src == 5'd0) begin
            r.val = '0;
            return r;
        end
        for (int i = 0; i < 3; i++) begin
            if (w[i] && n[i] == src) begin
                if (i == 0 && ex_m2reg) begin
                    r.stall = use_it;
                    continue;
                end
                if (i == 2 && !BYP) begin
                    r.stall = r.stall | use_it;
                    return r;
                end
                r.val = d[i];
                return r;
            end
        end
        return r;
    endfunction

    typedef struct {
        logic [4:0]    rs;
        logic          use_it;
        logic          exw, exld;
        logic [4:0]    exwn;
        logic          mw;
        logic [4:0]    mwn;
        logic          ww;
        logic [4:0]    wwn;
        logic [DW-1:0] exd, md, wd, q;
        logic          haz;
        logic [DW-1:0] exp_a;
    } vec_t;

    vec_t tbl[11];

    logic          m_valid;
    logic [DW-1:0] m_pc, m_a, m_b;
    logic [CNTW-1:0] m_cnt;
    res_t ra, rb;
    logic e_haz, e_rdy;

    initial begin
        //          rs   use exw exld exwn mw mwn  ww wwn   exd       md     wd     q      haz           exp_a
        tbl[0]  = '{5'd3, 1, 1, 0, 5'd3, 1, 5'd3, 0, 5'd0, 32'h11,   32'h22, 32'h33, 32'h44, 1'b0,        32'h11};
        tbl[1]  = '{5'd3, 1, 1, 0, 5'd4, 1, 5'd3, 1, 5'd3, 32'h11,   32'h22, 32'h33, 32'h44, 1'b0,        32'h22};
        tbl[2]  = '{5'd3, 1, 0, 0, 5'd3, 0, 5'd3, 1, 5'd3, 32'h11,   32'h22, 32'h33, 32'h44, !BYP,        32'h33};
        tbl[3]  = '{5'd3, 1, 0, 0, 5'd3, 0, 5'd3, 0, 5'd3, 32'h11,   32'h22, 32'h33, 32'h44, 1'b0,        32'h44};
        tbl[4]  = '{5'd0, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'hFFFF, 32'h22, 32'h33, 32'h44, 1'b0,        32'h0};
        tbl[5]  = '{5'd5, 1, 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 32'h11,   32'h22, 32'h33, 32'h44, 1'b1,        32'h0};
        tbl[6]  = '{5'd5, 1, 1, 0, 5'd5, 1, 5'd5, 0, 5'd0, 32'h11,   32'h22, 32'h33, 32'h44, 1'b0,        32'h11};
        tbl[7]  = '{5'd0, 1, 0, 0, 5'd0, 1, 5'd0, 1, 5'd0, 32'h11,   32'h22, 32'h33, 32'h44, 1'b0,        32'h0};
        tbl[8]  = '{5'd7, 0, 0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 32'h11,   32'h22, 32'h33, 32'h44, 1'b0,        BYP ? 32'h33 : 32'h44};
        tbl[9]  = '{5'd9, 1, 0, 1, 5'd9, 1, 5'd9, 0, 5'd0, 32'h11,   32'h22, 32'h33, 32'h44, 1'b0,        32'h22};
        tbl[10] = '{5'd31,1, 1, 0, 5'd30,1, 5'd31,0, 5'd0, 32'h11,   32'h22, 32'h33, 32'h44, 1'b0,        32'h22};

        idle();
        clrn = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_a", out_a, 0);
        check("rst_out_b", out_b, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        clrn = 1;
        #1 check("rst_in_ready", in_ready, 1);

        // load-use on rt, then MEM forwards the loaded value
        @(negedge clk);
        idle(); in_valid = 1; in_pc = 32'h40; rt = 5; use_rt = 1;
        ex_wreg = 1; ex_m2reg = 1; ex_wn = 5; ex_alu = 32'h77;
        #1;
        check("lu_hazard", hazard, 1);
        check("lu_in_ready", in_ready, 0);
        check("lu_cnt0", stall_cnt, 0);
        @(posedge clk); #1;
        check("lu_bubble", out_valid, 0);
        check("lu_cnt1", stall_cnt, 1);
        @(negedge clk);
        ex_wreg = 0; ex_m2reg = 0; mem_wreg = 1; mem_wn = 5; mem_data = 32'h5A5A;
        #1;
        check("lu_hazard_clr", hazard, 0);
        check("lu_in_ready_set", in_ready, 1);
        @(posedge clk); #1;
        check("lu_out_valid", out_valid, 1);
        check("lu_out_b", out_b, 32'h5A5A);
        check("lu_out_pc", out_pc, 32'h40);

        // operand resolution table
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            idle();
            in_valid = 1; in_pc = 32'h1000 + i * 4;
            rs = tbl[i].rs; use_rs = tbl[i].use_it; qa = tbl[i].q;
            ex_wreg = tbl[i].exw; ex_m2reg = tbl[i].exld; ex_wn = tbl[i].exwn; ex_alu = tbl[i].exd;
            mem_wreg = tbl[i].mw; mem_wn = tbl[i].mwn; mem_data = tbl[i].md;
            wb_wreg = tbl[i].ww; wb_wn = tbl[i].wwn; wb_data = tbl[i].wd;
            #1;
            check($sformatf("tbl%0d_hazard", i), hazard, tbl[i].haz);
            check($sformatf("tbl%0d_rna", i), rna, tbl[i].rs);
            @(posedge clk); #1;
            if (tbl[i].haz) begin
                check($sformatf("tbl%0d_bubble", i), out_valid, 0);
            end else begin
                check($sformatf("tbl%0d_valid", i), out_valid, 1);
                check($sformatf("tbl%0d_out_a", i), out_a, tbl[i].exp_a);
            end
        end

        // WB match with stale regfile data
        @(negedge clk);
        idle(); in_valid = 1; in_pc = 32'h80; rs = 7; use_rs = 1; qa = 0;
        wb_wreg = 1; wb_wn = 7; wb_data = 32'hABCD;
        #1;
        check("wb_hazard", hazard, !BYP);
        if (!BYP) begin
            check("wb_in_ready", in_ready, 0);
            @(posedge clk); #1;
            check("wb_bubble", out_valid, 0);
            @(negedge clk);
            wb_wreg = 0; qa = 32'hABCD;
            #1 check("wb_hazard_clr", hazard, 0);
        end
        @(posedge clk); #1;
        check("wb_valid", out_valid, 1);
        check("wb_out_a", out_a, 32'hABCD);

        // backpressure hold, then flush overrides the hold
        @(negedge clk);
        idle(); in_valid = 1; in_pc = 32'h100; rs = 1; rt = 2; use_rs = 1; use_rt = 1;
        qa = 32'hA1; qb = 32'hB2;
        @(posedge clk); #1;
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 0; in_pc = 32'h104 + i; qa = 32'h55 + i; qb = 32'h66 + i;
            #1 check("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_pc", out_pc, 32'h100);
            check("bp_hold_a", out_a, 32'hA1);
            check("bp_hold_b", out_b, 32'hB2);
        end
        @(negedge clk);
        flush = 1;
        #1 check("fl_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("fl_out_valid", out_valid, 0);

        // randomized run against the reference model, from a fresh reset
        @(negedge clk);
        idle(); clrn = 0;
        @(negedge clk);
        clrn = 1;
        m_valid = 0; m_pc = '0; m_a = '0; m_b = '0; m_cnt = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_pc = $urandom;
            rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
            use_rs = 1'($urandom_range(0, 1)); use_rt = 1'($urandom_range(0, 1));
            qa = $urandom; qb = $urandom;
            ex_wreg = 1'($urandom_range(0, 1)); ex_m2reg = ($urandom_range(0, 3) == 0);
            ex_wn = 5'($urandom_range(0, 7)); ex_alu = $urandom;
            mem_wreg = 1'($urandom_range(0, 1)); mem_wn = 5'($urandom_range(0, 7)); mem_data = $urandom;
            wb_wreg = 1'($urandom_range(0, 1)); wb_wn = 5'($urandom_range(0, 7)); wb_data = $urandom;
            #1;
            ra = resolve(rs, use_rs, qa);
            rb = resolve(rt, use_rt, qb);
            e_haz = in_valid && (ra.stall || rb.stall);
            e_rdy = (!m_valid || out_ready) && !e_haz && !flush;
            check("rnd_rna", rna, rs);
            check("rnd_rnb", rnb, rt);
            check("rnd_hazard", hazard, e_haz);
            check("rnd_in_ready", in_ready, e_rdy);
            if (flush) begin
                m_valid = 0;
            end else if (!m_valid || out_ready) begin
                m_valid = in_valid && e_rdy;
                if (m_valid) begin
                    m_pc = in_pc; m_a = ra.val; m_b = rb.val;
                end
            end
            if (e_haz && m_cnt != '1) m_cnt = m_cnt + 1'b1;
            @(posedge clk); #1;
            check("rnd_out_valid", out_valid, m_valid);
            check("rnd_out_pc", out_pc, m_pc);
            check("rnd_out_a", out_a, m_a);
            check("rnd_out_b", out_b, m_b);
            check("rnd_stall_cnt", stall_cnt, m_cnt);
        end

        // async reset in the middle of a held, stalled instruction
        @(negedge clk);
        idle(); in_valid = 1; in_pc = 32'h200; rs = 1; use_rs = 1; qa = 32'h99;
        @(posedge clk); #1;
        check("mr_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 0; ex_wreg = 1; ex_m2reg = 1; ex_wn = 1;
        #1 check("mr_hazard", hazard, 1);
        @(posedge clk); #1;
        check("mr_cnt", stall_cnt, m_cnt + 1'b1);
        #3 clrn = 0;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_stall_cnt", stall_cnt, 0);
        check("mr_out_pc", out_pc, 0);
        check("mr_out_a", out_a, 0);
        @(negedge clk);
        clrn = 1; out_ready = 1;

        // saturation: hazard held for 2^CNTW+5 clocks
        for (int i = 1; i <= (1 << CNTW) + 5; i++) begin
            @(posedge clk); #1;
            if (i == (1 << CNTW) - 2) check("sat_pre", stall_cnt, (1 << CNTW) - 2);
            if (i == (1 << CNTW) - 1) check("sat_hit", stall_cnt, (1 << CNTW) - 1);
        end
        check("sat_hold", stall_cnt, (1 << CNTW) - 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
